// File: rtl/syn_fifo_pkg.sv
// rtl/syn_fifo_pkg.sv - read-mode and default-geometry constants for the synchronous FIFO
package syn_fifo_pkg;

  // Read modes: registered output (one-cycle latency) or first-word-fall-through.
  localparam int MODE_REGISTERED = 0;
  localparam int MODE_FWFT       = 1;

  // Default geometry.
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/syn_fifo_ram.sv
// rtl/syn_fifo_ram.sv - M x N FIFO storage, synchronous write, asynchronous read
//
// Ports:
//   clk        write clock
//   write_en   store write_data at write_addr on the rising edge
//   write_addr write index
//   write_data word to store
//   read_addr  read index
//   read_data  word at read_addr (combinational)
module syn_fifo_ram #(
  parameter int N = 4,
  parameter int M = 16,
  parameter int D = $clog2(M)
) (
  input  logic         clk,
  input  logic         write_en,
  input  logic [D-1:0] write_addr,
  input  logic [N-1:0] write_data,
  input  logic [D-1:0] read_addr,
  output logic [N-1:0] read_data
);

  // Contents are deliberately not reset; the pointers define what is valid.
  logic [N-1:0] mem [M];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/syn_fifo_fwft.sv
// rtl/syn_fifo_fwft.sv - synchronous FIFO with registered or first-word-fall-through read
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous active-high reset
//   flush         synchronous clear of pointers, count and sticky flags
//   write_en      push request (accepted when not full)
//   read_en       pop request (accepted when not empty)
//   data_in       push data
//   data_out      popped word (registered mode) or head word (FWFT mode)
//   full, empty   occupancy flags
//   almost_full   count >= AF_LVL
//   almost_empty  count <= AE_LVL
//   count         words stored, 0..M
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module syn_fifo_fwft
  import syn_fifo_pkg::*;
#(
  parameter int N      = DEF_WIDTH,
  parameter int M      = DEF_DEPTH,
  parameter int D      = $clog2(M),
  parameter int FWFT   = MODE_REGISTERED,
  parameter int AF_LVL = M - 2,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         write_en,
  input  logic         read_en,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [D:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [D:0] PTR_ONE = (D+1)'(1);
  localparam logic [D:0] AF_CNT  = (D+1)'(AF_LVL);
  localparam logic [D:0] AE_CNT  = (D+1)'(AE_LVL);

  // Pointers carry one extra wrap bit so all M locations are usable.
  logic [D:0]   wr_ptr;
  logic [D:0]   rd_ptr;
  logic [N-1:0] head;
  logic         push;
  logic         pop;

  assign full  = (wr_ptr[D] != rd_ptr[D]) && (wr_ptr[D-1:0] == rd_ptr[D-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Acceptance depends only on registered full/empty, so a pop cannot make
  // room for a same-cycle push and a push cannot feed a same-cycle pop.
  assign push = write_en && !full;
  assign pop  = read_en && !empty;

  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  syn_fifo_ram #(
    .N (N),
    .M (M),
    .D (D)
  ) u_ram (
    .clk        (clk),
    .write_en   (push && !flush),
    .write_addr (wr_ptr[D-1:0]),
    .write_data (data_in),
    .read_addr  (rd_ptr[D-1:0]),
    .read_data  (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
      if (write_en && full) overflow  <= 1'b1;
      if (read_en && empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      // Head word is visible as soon as the write edge has updated the pointer.
      assign data_out = head;
    end else begin : g_reg
      logic [N-1:0] dout_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)      dout_q <= '0;
        else if (flush) dout_q <= '0;
        else if (pop)   dout_q <= head;
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_syn_fifo_fwft.sv
// tb/tb_syn_fifo_fwft.sv - directed vector bench for syn_fifo_fwft in both read modes
module tb_syn_fifo_fwft;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic [3:0] data_in = 4'h0;

  logic [3:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  syn_fifo_fwft #(.N(4), .M(16), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  syn_fifo_fwft #(.N(4), .M(16), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    logic       f, we, re;
    logic [3:0] din;
    int         cnt;
    logic       ovf, unf;
    logic [3:0] d0;
    logic       c1;
    logic [3:0] d1;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic f, input logic we, input logic re, input logic [3:0] din,
                         input int cnt, input logic ovf, input logic unf,
                         input logic [3:0] d0, input logic c1, input logic [3:0] d1);
    vec_t v;
    v.f = f; v.we = we; v.re = re; v.din = din; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.d0 = d0; v.c1 = c1; v.d1 = d1;
    vq.push_back(v);
  endtask

  task automatic step(input logic f, input logic we, input logic re, input logic [3:0] din);
    flush = f; write_en = we; read_en = re; data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill then overfill, drain then underdrain, flush.
    for (int i = 0; i < 16; i++) add_vec(0, 1, 0, 4'(i), i + 1, 0, 0, 4'h0, 1, 4'h0);
    add_vec(0, 1, 0, 4'h5, 16, 1, 0, 4'h0, 1, 4'h0);
    for (int i = 0; i < 16; i++) add_vec(0, 0, 1, 4'h0, 15 - i, 1, 0, 4'(i), i < 15, 4'(i + 1));
    add_vec(0, 0, 1, 4'h0, 0, 1, 1, 4'hF, 0, 4'h0);
    add_vec(1, 1, 0, 4'h3, 0, 0, 0, 4'h0, 0, 4'h0);
    // Full with simultaneous push/pop, then empty with simultaneous push/pop.
    for (int i = 0; i < 16; i++) add_vec(0, 1, 0, 4'(15 - i), i + 1, 0, 0, 4'h0, 1, 4'hF);
    add_vec(0, 1, 1, 4'h7, 15, 1, 0, 4'hF, 1, 4'hE);
    for (int i = 0; i < 15; i++) add_vec(0, 0, 1, 4'h0, 14 - i, 1, 0, 4'(14 - i), i < 14, 4'(13 - i));
    add_vec(0, 1, 1, 4'h9, 1, 1, 1, 4'h0, 1, 4'h9);
    add_vec(1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0);

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst count", 32'(count0), 32'd0);
    check("rst empty", 32'(empty0), 32'd1);
    check("rst full", 32'(full0), 32'd0);
    check("rst almost_empty", 32'(ae0), 32'd1);
    check("rst almost_full", 32'(af0), 32'd0);
    check("rst overflow", 32'(ovf0), 32'd0);
    check("rst underflow", 32'(unf0), 32'd0);
    check("rst data_out", 32'(dout0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      vec_t v;
      v = vq[k];
      step(v.f, v.we, v.re, v.din);
      check($sformatf("v%0d count", k), 32'(count0), 32'(v.cnt));
      check($sformatf("v%0d full", k), 32'(full0), 32'(v.cnt == 16));
      check($sformatf("v%0d empty", k), 32'(empty0), 32'(v.cnt == 0));
      check($sformatf("v%0d almost_full", k), 32'(af0), 32'(v.cnt >= 14));
      check($sformatf("v%0d almost_empty", k), 32'(ae0), 32'(v.cnt <= 2));
      check($sformatf("v%0d overflow", k), 32'(ovf0), 32'(v.ovf));
      check($sformatf("v%0d underflow", k), 32'(unf0), 32'(v.unf));
      check($sformatf("v%0d data_out reg", k), 32'(dout0), 32'(v.d0));
      check($sformatf("v%0d count fwft", k), 32'(count1), 32'(v.cnt));
      if (v.c1) check($sformatf("v%0d data_out fwft", k), 32'(dout1), 32'(v.d1));
    end

    // FWFT: a word written into an empty FIFO shows without read_en.
    step(0, 1, 0, 4'hA);
    check("fwft push data_out", 32'(dout1), 32'hA);
    check("fwft push empty", 32'(empty1), 32'd0);
    step(0, 0, 0, 4'h0);
    check("fwft idle data_out", 32'(dout1), 32'hA);
    check("reg idle data_out", 32'(dout0), 32'h0);
    step(0, 0, 1, 4'h0);
    check("fwft pop empty", 32'(empty1), 32'd1);
    check("reg pop data_out", 32'(dout0), 32'hA);

    // Sustained push+pop at count 8 across pointer wrap.
    for (int k = 0; k < 8; k++) step(0, 1, 0, 4'(k));
    check("wrap prefill count", 32'(count0), 32'd8);
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 1, 4'(8 + k));
      check($sformatf("wrap%0d count", k), 32'(count0), 32'd8);
      check($sformatf("wrap%0d data_out reg", k), 32'(dout0), 32'(k % 16));
      check($sformatf("wrap%0d data_out fwft", k), 32'(dout1), 32'((k + 1) % 16));
    end
    step(1, 0, 0, 4'h0);

    // Flush with a same-cycle push at count 9.
    step(0, 0, 1, 4'h0);
    check("flush pre underflow", 32'(unf0), 32'd1);
    for (int k = 0; k < 9; k++) step(0, 1, 0, 4'(k + 1));
    check("flush pre count", 32'(count0), 32'd9);
    step(1, 1, 0, 4'hC);
    check("flush count", 32'(count0), 32'd0);
    check("flush empty", 32'(empty0), 32'd1);
    check("flush underflow", 32'(unf0), 32'd0);
    check("flush almost_empty", 32'(ae0), 32'd1);
    check("flush fwft count", 32'(count1), 32'd0);

    // Same scenario, cleared by an asynchronous reset between edges.
    step(0, 0, 1, 4'h0);
    for (int k = 0; k < 9; k++) step(0, 1, 0, 4'(k + 1));
    step(0, 0, 1, 4'h0);
    check("arst pre count", 32'(count0), 32'd8);
    check("arst pre data_out", 32'(dout0), 32'h1);
    check("arst pre underflow", 32'(unf0), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst count", 32'(count0), 32'd0);
    check("arst empty", 32'(empty0), 32'd1);
    check("arst data_out", 32'(dout0), 32'h0);
    check("arst underflow", 32'(unf0), 32'd0);
    check("arst almost_empty", 32'(ae0), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 0, 4'h3);
    check("post reset count", 32'(count0), 32'd1);
    check("post reset fwft data_out", 32'(dout1), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
